cache_cmd_decoder: RTL and testbench

Front-end stage of the LLC model: accepts raw trace records (command code + 32-bit address) from the trace reader and feeds them to the cache controller. Validates the command code, splits the address into tag/index/byte-offset for the 8-way, 16 MB, 64 B-line cache, and buffers requests in a small FIFO with valid/ready handshakes on both sides. Keeps running CPU read/write and illegal-command counters, which a CLR command zeroes.

---
 rtl/cache_cmd_decoder_pkg.sv | 43 ++++
 rtl/cache_cmd_decoder_cmd_fifo.sv | 59 +++++
 rtl/cache_cmd_decoder.sv | 104 ++++++++++
 tb/tb_cache_cmd_decoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_cmd_decoder_pkg.sv
// Shared types for the LLC trace front-end: address split for the 8-way, 16 MB,
// 64 B-line cache, the trace command codes and the request record.
package cache_cmd_decoder_pkg;

    localparam int ADDR_W     = 32;
    localparam int CMD_W      = 4;
    localparam int CAPACITY_W = 24;
    localparam int LINE_W     = 6;
    localparam int WAYS_W     = 3;

    // index = sets = capacity / (line * ways); tag takes the remaining bits
    localparam int OFFSET_W = LINE_W;
    localparam int INDEX_W  = CAPACITY_W - LINE_W - WAYS_W;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [CMD_W-1:0] {
        CMD_READ         = 4'd0,
        CMD_WRITE        = 4'd1,
        CMD_L1_READ      = 4'd2,
        CMD_SNOOP_INVAL  = 4'd3,
        CMD_SNOOPED_RD   = 4'd4,
        CMD_SNOOP_WR     = 4'd5,
        CMD_SNOOP_RDWITM = 4'd6,
        CMD_CLR          = 4'd8,
        CMD_PRINT        = 4'd9
    } cmd_e;

    typedef struct packed {
        cmd_e                cmd;
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
    } cache_req_t;

    function automatic logic is_legal_cmd(input logic [CMD_W-1:0] code);
        return (code <= 4'd6) || (code == 4'd8) || (code == 4'd9);
    endfunction

    function automatic logic is_snoop_cmd(input logic [CMD_W-1:0] code);
        return (code >= 4'd3) && (code <= 4'd6);
    endfunction

endpackage

// File: rtl/cache_cmd_decoder_cmd_fifo.sv
// Request FIFO between the trace decoder and the cache controller.
// Power-of-two depth, so the read/write pointers wrap naturally.
module cmd_fifo
    import cache_cmd_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  cache_req_t             wr_data,
    input  logic                   pop,
    output cache_req_t             rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    cache_req_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cache_cmd_decoder.sv
// Trace front-end: validates command codes, splits addresses into tag/index/offset,
// buffers requests for the cache controller and keeps read/write/illegal statistics.
module cache_cmd_decoder
    import cache_cmd_decoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CMD_W-1:0]    in_cmd,
    input  logic [ADDR_W-1:0]   in_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CMD_W-1:0]    out_cmd,
    output logic [TAG_W-1:0]    out_tag,
    output logic [INDEX_W-1:0]  out_index,
    output logic [OFFSET_W-1:0] out_offset,
    output logic                out_is_snoop,
    output logic                err_illegal,
    output logic [CNT_W-1:0]    rd_cnt,
    output logic [CNT_W-1:0]    wr_cnt,
    output logic [CNT_W-1:0]    ill_cnt
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    cache_req_t       new_req;
    cache_req_t       head;
    logic [OCC_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             cmd_legal;
    logic             push;
    logic             pop;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready  = (fifo_count < OCC_W'(DEPTH));
    assign accept    = in_valid & in_ready;
    assign cmd_legal = is_legal_cmd(in_cmd);
    assign push      = accept & cmd_legal & ~fifo_full;
    assign pop       = out_ready & ~fifo_empty;

    assign new_req.cmd    = cmd_e'(in_cmd);
    assign new_req.tag    = in_addr[ADDR_W-1 -: TAG_W];
    assign new_req.index  = in_addr[OFFSET_W +: INDEX_W];
    assign new_req.offset = in_addr[OFFSET_W-1:0];

    cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (new_req),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head fields are masked to zero so an empty FIFO never shows stale data
    assign out_valid    = ~fifo_empty;
    assign out_cmd      = out_valid ? head.cmd    : '0;
    assign out_tag      = out_valid ? head.tag    : '0;
    assign out_index    = out_valid ? head.index  : '0;
    assign out_offset   = out_valid ? head.offset : '0;
    assign out_is_snoop = out_valid & is_snoop_cmd(head.cmd);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_illegal <= 1'b0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            ill_cnt     <= '0;
        end else begin
            err_illegal <= accept & ~cmd_legal;
            if (accept) begin
                if (in_cmd == CMD_CLR) begin
                    rd_cnt  <= '0;
                    wr_cnt  <= '0;
                    ill_cnt <= '0;
                end else if (!cmd_legal) begin
                    if (ill_cnt != '1) begin
                        ill_cnt <= ill_cnt + 1'b1;
                    end
                end else if (in_cmd == CMD_READ || in_cmd == CMD_L1_READ) begin
                    if (rd_cnt != '1) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end else if (in_cmd == CMD_WRITE) begin
                    if (wr_cnt != '1) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_cmd_decoder.sv
// Scoreboard bench for cache_cmd_decoder: the driver predicts accepted requests and
// statistics from the command rules; a separate monitor checks every handshake.
module tb_cache_cmd_decoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_cmd = '0;
    logic [31:0] in_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_cmd;
    logic [10:0] out_tag;
    logic [14:0] out_index;
    logic [5:0]  out_offset;
    logic        out_is_snoop;
    logic        err_illegal;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] ill_cnt;

    cache_cmd_decoder #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cmd       (in_cmd),
        .in_addr      (in_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_cmd      (out_cmd),
        .out_tag      (out_tag),
        .out_index    (out_index),
        .out_offset   (out_offset),
        .out_is_snoop (out_is_snoop),
        .err_illegal  (err_illegal),
        .rd_cnt       (rd_cnt),
        .wr_cnt       (wr_cnt),
        .ill_cnt      (ill_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [10:0] tag;
        logic [14:0] index;
        logic [5:0]  offset;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          modelOcc = 0;
    logic [31:0] expRd = '0;
    logic [31:0] expWr = '0;
    logic [31:0] expIll = '0;
    logic        expErr = 1'b0;

    function automatic void check(input string name, input logic [63:0] actual,
                                  input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic logic isLegal(input logic [3:0] c);
        return (c <= 4'd6) || (c == 4'd8) || (c == 4'd9);
    endfunction

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic checkOutput();
        check("err_illegal", err_illegal, expErr);
        check("rd_cnt", rd_cnt, expRd);
        check("wr_cnt", wr_cnt, expWr);
        check("ill_cnt", ill_cnt, expIll);
    endtask

    // One clock of stimulus; model is advanced just after the edge it describes
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [31:0] a,
                                 input logic r);
        logic acc;
        logic legal;
        logic popped;
        exp_t e;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = v;
        in_cmd    = c;
        in_addr   = a;
        out_ready = r;
        acc    = v && (modelOcc < DEPTH);
        legal  = isLegal(c);
        popped = r && (modelOcc > 0);
        @(posedge clk);
        #1;
        if (acc && legal) begin
            e.cmd    = c;
            e.tag    = 11'(a >> 21);
            e.index  = 15'((a >> 6) & 32'h7FFF);
            e.offset = 6'(a & 32'h3F);
            expQ.push_back(e);
        end
        modelOcc = modelOcc + ((acc && legal) ? 1 : 0) - (popped ? 1 : 0);
        if (acc) begin
            if (c == 4'd8) begin
                expRd  = '0;
                expWr  = '0;
                expIll = '0;
            end else if (!legal) begin
                expIll = satInc(expIll);
            end else if (c == 4'd0 || c == 4'd2) begin
                expRd = satInc(expRd);
            end else if (c == 4'd1) begin
                expWr = satInc(expWr);
            end
        end
        expErr = acc && !legal;
        checkOutput();
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        expQ.delete();
        modelOcc = 0;
        expRd    = '0;
        expWr    = '0;
        expIll   = '0;
        expErr   = 1'b0;
        checkOutput();
    endtask

    // Monitor: samples one time unit before each rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                check("in_ready", in_ready, modelOcc < DEPTH);
                check("out_valid", out_valid, expQ.size() > 0);
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_pop actual=request expected=none at %0t", $time);
                    end else begin
                        e = expQ.pop_front();
                        check("out_cmd", out_cmd, e.cmd);
                        check("out_tag", out_tag, e.tag);
                        check("out_index", out_index, e.index);
                        check("out_offset", out_offset, e.offset);
                        check("out_is_snoop", out_is_snoop, (e.cmd >= 4'd3) && (e.cmd <= 4'd6));
                    end
                end else if (!out_valid) begin
                    check("idle_fields", {out_cmd, out_tag, out_index, out_offset, out_is_snoop}, '0);
                end
            end
        end
    end

    initial begin
        applyReset();

        // Single read, then drain
        applyStimulus(1'b1, 4'd0, 32'h1234_5678, 1'b1);
        repeat (2) applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);

        // Overfill with writes while stalled, then release
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'd1, $urandom, 1'b0);
        applyStimulus(1'b1, 4'd1, 32'hDEAD_BEEF, 1'b1);
        applyStimulus(1'b1, 4'd1, 32'hDEAD_BEEF, 1'b1);
        repeat (6) applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);

        // Illegal codes
        applyStimulus(1'b1, 4'd7, $urandom, 1'b1);
        applyStimulus(1'b1, 4'd12, $urandom, 1'b1);
        repeat (2) applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);

        // Ordered stream through CLR
        applyStimulus(1'b1, 4'd0, $urandom, 1'b1);
        applyStimulus(1'b1, 4'd1, $urandom, 1'b1);
        applyStimulus(1'b1, 4'd2, $urandom, 1'b1);
        applyStimulus(1'b1, 4'd8, $urandom, 1'b1);
        applyStimulus(1'b1, 4'd0, $urandom, 1'b1);
        repeat (3) applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);

        // Snoops and PRINT
        for (int c = 3; c <= 6; c++) applyStimulus(1'b1, 4'(c), $urandom, 1'b1);
        applyStimulus(1'b1, 4'd9, $urandom, 1'b1);
        repeat (3) applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);

        // Reset with three requests queued
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd0, $urandom, 1'b0);
        applyReset();
        repeat (3) applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom,
                          $urandom_range(0, 9) < 6);
        end
        repeat (8) applyStimulus(1'b0, 4'd0, 32'h0, 1'b1);
        check("queue_drained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
